// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serializer: start bit, LSB-first data bits, optional even parity, stop bit
//
// Purpose:
//   Frames a parallel word onto an idle-high serial line. Bit timing comes from
//   a 16x oversampling tick shared with the receiver, so each start/data bit
//   spans SB_TICKS ticks and the stop bit spans STP_BITS_TICKS ticks.
//   Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
//   (SB_TICKS long) between the last data bit and the stop bit.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_bd_tick   single-cycle oversampling tick
//   i_tx_start  send request, honoured only while idle
//   i_data      word to send, captured on the accepting edge
//   o_tx        registered serial line, idle high
//   o_tx_busy   high from the cycle after acceptance until frame completion
//   o_tx_done   one-cycle pulse when the stop bit finishes

module uart_transmitter #(
    parameter int DATA_BITS      = 8,
    parameter int SB_TICKS       = 16,
    parameter int STP_BITS_TICKS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bd_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int MAX_TICKS = (SB_TICKS > STP_BITS_TICKS) ? SB_TICKS : STP_BITS_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICKS - 1);
    localparam logic [TICK_W-1:0] STP_LAST = TICK_W'(STP_BITS_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A tick coinciding with acceptance is deliberately not counted.
                if (i_tx_start) begin
                    shreg_d    = i_data;
                    tick_cnt_d = '0;
                    state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^i_data;
`endif
                end
            end
            ST_START: begin
                if (i_bd_tick) begin
                    if (tick_cnt_q == SB_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_bd_tick) begin
                    if (tick_cnt_q == SB_LAST) begin
                        tick_cnt_d = '0;
                        shreg_d    = shreg_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (i_bd_tick) begin
                    if (tick_cnt_q == SB_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_bd_tick) begin
                    if (tick_cnt_q == STP_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so the registered output
    // changes on the same edge as the state and can never glitch.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized self-checking bench for uart_transmitter against a frame-level model

module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_TICKS = 176;
`else
    localparam int FRAME_TICKS = 160;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_bd_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_busy;
    logic       o_tx_done;

    uart_transmitter dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_bd_tick  (i_bd_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Frame-level reference: a frame is just a count of ticks since acceptance.
    bit         m_busy = 1'b0;
    int         m_ticks = 0;
    logic [7:0] m_word = 8'h00;
    logic       e_tx, e_busy, e_done;
    int         exp_done_cnt = 0;
    int         obs_done_cnt = 0;
    int         tick_period = 4;
    int         tick_phase = 0;
    bit         noise = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Line level after n counted ticks: slot 0 start, 1..8 data LSB first,
    // then optional parity, then stop.
    function automatic logic line_bit(input logic [7:0] w, input int n);
        int slot;
        slot = n / 16;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return w[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^w;
`endif
        return 1'b1;
    endfunction

    // One clock: drive tick, advance model with pre-edge inputs, check after edge.
    task automatic step();
        i_bd_tick  = (tick_phase == 0);
        tick_phase = (tick_phase + 1) % tick_period;
        e_done = 1'b0;
        if (i_reset) begin
            m_busy = 1'b0;
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end else if (!m_busy) begin
            if (i_tx_start) begin
                m_busy  = 1'b1;
                m_ticks = 0;
                m_word  = i_data;
                e_tx    = 1'b0;
                e_busy  = 1'b1;
            end else begin
                e_tx   = 1'b1;
                e_busy = 1'b0;
            end
        end else begin
            if (i_bd_tick) m_ticks++;
            if (m_ticks == FRAME_TICKS) begin
                m_busy = 1'b0;
                e_tx   = 1'b1;
                e_busy = 1'b0;
                e_done = 1'b1;
                exp_done_cnt++;
            end else begin
                e_tx   = line_bit(m_word, m_ticks);
                e_busy = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
        check_eq("tx", o_tx, e_tx);
        check_eq("busy", o_tx_busy, e_busy);
        check_eq("done", o_tx_done, e_done);
        if (o_tx_done === 1'b1) obs_done_cnt++;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_busy && guard < 2000) begin
            if (noise) begin
                i_tx_start = ($urandom_range(0, 7) == 0);
                i_data     = 8'($urandom);
            end
            step();
            guard++;
        end
        i_tx_start = 1'b0;
        check_eq("frame_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d);
        i_tx_start = 1'b1;
        i_data     = d;
        step();
        i_tx_start = 1'b0;
        wait_idle();
        step();
    endtask

    initial begin
        int guard;
        i_reset    = 1'b1;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        i_bd_tick  = 1'b0;
        repeat (3) step();
        i_reset = 1'b0;

        // idle with ticks running, stray data changes
        repeat (1000) begin
            i_data = 8'($urandom);
            step();
        end

        run_frame(8'hA5);

        // mid-frame requests with other data must be ignored
        noise = 1'b1;
        run_frame(8'hFF);
        noise = 1'b0;

        // start held high: back-to-back frames with one idle clock between
        i_tx_start = 1'b1;
        i_data     = 8'h55;
        guard = 0;
        begin
            int target;
            target = exp_done_cnt + 3;
            while (exp_done_cnt < target && guard < 3000) begin
                step();
                guard++;
            end
            i_tx_start = 1'b0;
            check_eq("hold_timeout", 32'(exp_done_cnt), 32'(target));
        end
        wait_idle();
        step();

        // asynchronous reset at tick 70 of a frame
        i_tx_start = 1'b1;
        i_data     = 8'h0F;
        step();
        i_tx_start = 1'b0;
        guard = 0;
        while (m_ticks < 70 && guard < 2000) begin
            step();
            guard++;
        end
        check_eq("reset_wait_timeout", 32'(m_ticks), 32'd70);
        #2;
        i_reset = 1'b1;
        #1;
        check_eq("async_rst_tx", o_tx, 1'b1);
        check_eq("async_rst_busy", o_tx_busy, 1'b0);
        check_eq("async_rst_done", o_tx_done, 1'b0);
        m_busy = 1'b0;
        repeat (2) step();
        i_reset = 1'b0;
        step();
        run_frame(8'h81);

        // parity cases (plain frames when parity is disabled)
        run_frame(8'h07);
        run_frame(8'h03);

        // randomized frames, tick rates and phases, with mid-frame noise
        noise = 1'b1;
        repeat (20) begin
            tick_period = $urandom_range(2, 6);
            tick_phase  = $urandom_range(0, tick_period - 1);
            repeat ($urandom_range(0, 5)) step();
            run_frame(8'($urandom));
        end
        noise = 1'b0;

        check_eq("done_count", 32'(obs_done_cnt), 32'(exp_done_cnt));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
